// File: rtl/regfile_dump_scanner.sv
// Snapshots the packed register image and streams it as (index, value) beats over valid/ready.
// Define REG0_SKIP_EN to omit the hardwired register 0 from every scan.
module regfile_dump_scanner #(
   parameter int NREGS = 8,
   parameter int WIDTH = 8,
   parameter int IDXW  = 3,
   parameter int DWELL = 50000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREGS*WIDTH-1:0] data_in,
   input  logic                   start,
   input  logic                   auto,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IDXW-1:0]        out_idx,
   output logic [WIDTH-1:0]       out_val,
   output logic                   busy,
   output logic                   done
);

   localparam int CW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
   localparam logic [CW-1:0]   DWELL_LOAD = CW'((DWELL > 0) ? DWELL - 1 : 0);
   localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NREGS - 1);
`ifdef REG0_SKIP_EN
   localparam logic [IDXW-1:0] FIRST_IDX  = IDXW'(1);
`else
   localparam logic [IDXW-1:0] FIRST_IDX  = IDXW'(0);
`endif

   typedef enum logic [1:0] {IDLE, PRESENT, DWELL_WAIT} state_t;

   state_t                 state, state_d;
   logic [NREGS*WIDTH-1:0] snap, snap_d;
   logic                   mode, mode_d;
   logic [CW-1:0]          cnt, cnt_d;
   logic [IDXW-1:0]        idx_d;
   logic [WIDTH-1:0]       val_d;
   logic                   valid_d, busy_d, done_d;

   // Register 0 sits in the MSBs of the image.
   function automatic logic [WIDTH-1:0] pick(input logic [NREGS*WIDTH-1:0] img,
                                             input logic [IDXW-1:0] idx);
      return img[(NREGS - 1 - int'(idx)) * WIDTH +: WIDTH];
   endfunction

   // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
   always_comb begin
      state_d = state;
      snap_d  = snap;
      mode_d  = mode;
      cnt_d   = cnt;
      idx_d   = out_idx;
      val_d   = out_val;
      valid_d = out_valid;
      busy_d  = busy;
      done_d  = 1'b0;
      case (state)
         IDLE: begin
            if (start || auto) begin
               snap_d  = data_in;
               mode_d  = auto;
               idx_d   = FIRST_IDX;
               val_d   = pick(data_in, FIRST_IDX);
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (out_valid && out_ready) begin
               if (out_idx == LAST_IDX) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else if (mode && DWELL > 0) begin
                  valid_d = 1'b0;
                  cnt_d   = DWELL_LOAD;
                  state_d = DWELL_WAIT;
               end else begin
                  idx_d = out_idx + IDXW'(1);
                  val_d = pick(snap, idx_d);
               end
            end
         end
         DWELL_WAIT: begin
            // Loaded with DWELL-1 and released on reaching zero: exactly DWELL idle cycles.
            if (cnt == '0) begin
               idx_d   = out_idx + IDXW'(1);
               val_d   = pick(snap, idx_d);
               valid_d = 1'b1;
               state_d = PRESENT;
            end else begin
               cnt_d = cnt - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         // NOTE: the snapshot is plain flops, not a RAM, so clearing it on reset is cheap and intended.
         snap      <= '0;
         mode      <= 1'b0;
         cnt       <= '0;
         out_idx   <= '0;
         out_val   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_d;
         snap      <= snap_d;
         mode      <= mode_d;
         cnt       <= cnt_d;
         out_idx   <= idx_d;
         out_val   <= val_d;
         out_valid <= valid_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_regfile_dump_scanner.sv
// Directed self-checking bench for regfile_dump_scanner (DWELL overridden to 4).
module tb_regfile_dump_scanner;

   localparam int NREGS = 8;
   localparam int WIDTH = 8;
   localparam int IDXW  = 3;
   localparam int DWELL = 4;
`ifdef REG0_SKIP_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif
   localparam logic [63:0] IMG_A = 64'h0011223344556677;
   localparam logic [63:0] IMG_B = 64'h8899AABBCCDDEEF0;

   logic                   clk;
   logic                   rst_n;
   logic [NREGS*WIDTH-1:0] data_in;
   logic                   start;
   logic                   auto;
   logic                   out_valid;
   logic                   out_ready;
   logic [IDXW-1:0]        out_idx;
   logic [WIDTH-1:0]       out_val;
   logic                   busy;
   logic                   done;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_dump_scanner #(
      .NREGS(NREGS), .WIDTH(WIDTH), .IDXW(IDXW), .DWELL(DWELL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .start(start), .auto(auto),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_val(out_val), .busy(busy), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_val(input logic [63:0] img, input int idx);
      logic [63:0] tmp;
      tmp = img >> (8 * (7 - idx));
      return tmp[7:0];
   endfunction

   // Collects one scan starting at a negedge where the first beat is visible; returns at the done negedge.
   task automatic collect(input string tag, input logic [63:0] img, input bit bp,
                          input int exp_gap, input int drop_auto_idx);
      int nb = 0;
      int gap = 0;
      int exp_idx = FIRST;
      bit held = 0;
      bit got = 0;
      for (int c = 0; c < 300; c++) begin
         if (drop_auto_idx >= 0 && out_valid && int'(out_idx) == drop_auto_idx) auto = 1'b0;
         if (out_valid) begin
            if (bp && !held && out_idx == 3'd2) begin
               held = 1;
               out_ready = 1'b0;
               data_in = '1;
               start = 1'b1;
               for (int h = 0; h < 3; h++) begin
                  @(negedge clk);
                  check({tag, "_hold_idx"}, 64'(out_idx), 64'd2);
                  check({tag, "_hold_val"}, 64'(out_val), 64'h22);
                  check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
               end
               out_ready = 1'b1;
               start = 1'b0;
            end
            if (nb > 0) check({tag, "_gap"}, 64'(gap), 64'(exp_gap));
            check({tag, "_idx"}, 64'(out_idx), 64'(exp_idx));
            check({tag, "_val"}, 64'(out_val), 64'(ref_val(img, exp_idx)));
            check({tag, "_busy"}, 64'(busy), 64'd1);
            exp_idx++;
            nb++;
            gap = 0;
         end else if (done) begin
            check({tag, "_beats"}, 64'(nb), 64'(NREGS - FIRST));
            check({tag, "_busy_end"}, 64'(busy), 64'd0);
            got = 1;
            break;
         end else begin
            gap++;
         end
         @(negedge clk);
      end
      if (!got) check({tag, "_done_seen"}, 64'd0, 64'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      data_in = '0;
      start = 1'b0;
      auto = 1'b0;
      out_ready = 1'b0;
      #22;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_idx", 64'(out_idx), 64'd0);
      check("rst_val", 64'(out_val), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back manual scan
      data_in = IMG_A;
      out_ready = 1'b1;
      start = 1'b1;
      check("pre_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      start = 1'b0;
      collect("b2b", IMG_A, 0, 0, -1);
      @(negedge clk);
      check("b2b_done_pulse", 64'(done), 64'd0);
      check("b2b_idle_valid", 64'(out_valid), 64'd0);

      // Backpressure, snapshot isolation, start while busy
      data_in = IMG_A;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      collect("bp", IMG_A, 1, 0, -1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_no_restart", 64'(out_valid | busy), 64'd0);
      end

      // Auto mode with dwell; second scan takes fresh data and auto drops mid-scan
      data_in = IMG_A;
      auto = 1'b1;
      @(negedge clk);
      collect("auto1", IMG_A, 0, DWELL, -1);
      data_in = IMG_B;
      @(negedge clk);
      check("auto_recapture_valid", 64'(out_valid), 64'd1);
      collect("auto2", IMG_B, 0, DWELL, 3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("auto_stays_idle", 64'(out_valid | busy), 64'd0);
      end

      // Asynchronous reset mid-scan
      data_in = IMG_A;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         bit seen = 0;
         for (int c = 0; c < 50; c++) begin
            if (out_valid && out_idx == 3'd4) begin
               seen = 1;
               break;
            end
            @(negedge clk);
         end
         check("rst_reach_idx4", 64'(seen), 64'd1);
      end
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_idx", 64'(out_idx), 64'd0);
      check("arst_val", 64'(out_val), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_idle", 64'(out_valid | busy), 64'd0);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      collect("rescan", IMG_A, 0, 0, -1);
      @(negedge clk);
      check("rescan_done_pulse", 64'(done), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_dump_scanner.md
Name: regfile_dump_scanner

Overview:
- Reader side of the register file's 64-bit debug bus.
- Snapshots the packed register image, then streams each register as an (index, value) beat over a valid/ready handshake to a display or UART driver.
- Supports one-shot dumps on request, plus a free-running auto mode with a programmable dwell between registers for 7-segment viewing.

Parameters:
- NREGS, 8, number of registers in the debug image.
- WIDTH, 8, bits per register.
- IDXW, 3, index width; must equal clog2(NREGS).
- DWELL, 50000000, idle cycles inserted after each accepted beat in auto mode; 0 means no gap.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  NREGS*WIDTH  packed register image; register 0 occupies the MSBs [63:56], register 7 the LSBs [7:0].
- start  in  1  request a one-shot dump; sampled only in IDLE.
- auto  in  1  level; selects continuous scanning with dwell.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_idx  out  IDXW  register index of current beat.
- out_val  out  WIDTH  register value of current beat.
- busy  out  1  high from capture until end of scan.
- done  out  1  one-cycle pulse after the last beat of a scan is accepted.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE.
  - out_valid=0, out_idx=0, out_val=0, busy=0, done=0.
  - Snapshot and dwell counter cleared.
  - Takes effect immediately mid-scan; no beat completes after reset asserts.
- States: IDLE, PRESENT, DWELL_WAIT.
- IDLE:
  - On an edge with start=1 or auto=1: snapshot<=data_in, mode latched from auto, out_idx<=first index, out_val<=snapshot entry, out_valid<=1, busy<=1, go to PRESENT.
  - out_valid is therefore visible 1 cycle after start.
- PRESENT:
  - out_idx/out_val are held stable while out_valid=1 and out_ready=0.
  - A transfer occurs on an edge with out_valid&&out_ready.
  - Transfer, not last index, manual mode: idx increments and next value is presented with out_valid remaining 1, giving 1 beat/cycle throughput.
  - Transfer, not last index, auto mode with DWELL>0: out_valid<=0, counter<=DWELL-1, go to DWELL_WAIT.
  - Transfer at last index (NREGS-1):
    - out_valid<=0, busy<=0, done<=1 for exactly one cycle, state IDLE.
    - If auto is still high, IDLE recaptures on the next edge, taking fresh data_in.
- DWELL_WAIT:
  - Counter decrements each cycle.
  - At 0: idx increments, out_valid<=1, go to PRESENT.
  - Gap with out_valid=0 is exactly DWELL cycles.
- Snapshot semantics: data_in changes after capture do not affect the current scan.
- start during busy is ignored and not queued.
- auto deasserted mid-scan: the current scan completes in the latched mode; no restart.
- out_val is always snapshot[(NREGS-1-idx)*WIDTH +: WIDTH].
- Dwell counter width is clog2(DWELL+1); there is no wrap, because the counter only reloads on transfer.

Optional Feature:
- Macro REG0_SKIP_EN.
- Defined:
  - Register 0 (hardwired, never written) is omitted; scans cover idx 1..NREGS-1, giving 7 beats.
  - The first beat presents idx=1; done follows the idx 7 transfer.
- Undefined:
  - All NREGS registers are streamed starting at idx=0, giving 8 beats.

Test Plan:
- Back-to-back transfers:
  - Stimulus: data_in=64'h0011223344556677, out_ready=1, start pulse.
  - Response: out_valid rises the next cycle; 8 consecutive beats idx0..7 with values 00,11,...,77; done pulses 1 cycle after idx7; busy low thereafter.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles while idx=2.
  - Response: idx=2, val=22, valid=1 all stable for those 3 cycles; the beat completes when ready=1; total 8 beats, none duplicated or dropped.
- Snapshot isolation and start-while-busy:
  - Stimulus: change data_in to all-FF and pulse start during the scan.
  - Response: the scan still emits the original values; no second scan starts.
- Auto mode, DWELL=4:
  - Stimulus: auto=1, ready=1.
  - Response: exactly 4 cycles of valid=0 between beats; after done, a new scan reflects the updated data_in.
  - Stimulus: drop auto mid-scan.
  - Response: the scan finishes, then stays IDLE.
- Reset mid-scan:
  - Stimulus: rst_n low asynchronously at idx=4.
  - Response: all outputs 0 immediately, without waiting for a clock edge; after release, IDLE until start; the next scan restarts at the first index.
- REG0_SKIP_EN defined:
  - Stimulus: same data as the first scenario.
  - Response: 7 beats, idx1..7 with values 11..77; done after idx7.
